// File: rtl/fft_pkg.sv
// Shared types and default sizing for the FFT peak detector.
// The peak_result_t struct packs one frame's reported result.
package fft_pkg;

  localparam int N        = 1024;
  localparam int BIN_W    = $clog2(N);
  localparam int MAG_W    = 33;
  localparam int MIN_BIN  = 4;
  localparam int MAX_BIN  = 200;
  localparam int K_RATIO  = 8;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    CALC   = 2'd1,
    REPORT = 2'd2
  } peak_state_t;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic [MAG_W-1:0] mag;
    logic             detect;
  } peak_result_t;

endpackage

// File: rtl/fft_peak_detect_window_max.sv
// Running argmax and exact energy sum over the in-window bins of a frame.
// clr restores the empty-window state; en folds one bin into the window.
module window_max #(
  parameter int MW       = 33,
  parameter int BIN_W    = 10,
  parameter int SUM_W    = 43,
  parameter int INIT_BIN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [MW-1:0]    data,
  input  logic [BIN_W-1:0] bin,
  output logic [MW-1:0]    best_mag,
  output logic [BIN_W-1:0] best_bin,
  output logic [SUM_W-1:0] sum
);

  logic [MW-1:0]    best_mag_q, best_mag_d;
  logic [BIN_W-1:0] best_bin_q, best_bin_d;
  logic [SUM_W-1:0] sum_q, sum_d;

  always_comb begin
    best_mag_d = best_mag_q;
    best_bin_d = best_bin_q;
    sum_d      = sum_q;
    if (clr) begin
      best_mag_d = '0;
      best_bin_d = BIN_W'(INIT_BIN);
      sum_d      = '0;
    end else if (en) begin
      sum_d = sum_q + SUM_W'(data);
      // Strictly greater: on ties the earlier (lower) bin is kept.
      if (data > best_mag_q) begin
        best_mag_d = data;
        best_bin_d = bin;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_mag_q <= '0;
      best_bin_q <= BIN_W'(INIT_BIN);
      sum_q      <= '0;
    end else begin
      best_mag_q <= best_mag_d;
      best_bin_q <= best_bin_d;
      sum_q      <= sum_d;
    end
  end

  assign best_mag = best_mag_q;
  assign best_bin = best_bin_q;
  assign sum      = sum_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak finder: accumulates a window of magnitude bins, then reports
// the peak bin, its magnitude and whether it dominates the window mean by K.
import fft_pkg::*;

module fft_peak_detect #(
  parameter int MW      = fft_pkg::MAG_W,
  parameter int N       = fft_pkg::N,
  parameter int MIN_BIN = fft_pkg::MIN_BIN,
  parameter int MAX_BIN = fft_pkg::MAX_BIN,
  parameter int K       = fft_pkg::K_RATIO
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MW-1:0]        x_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [$clog2(N)-1:0] y_bin,
  output logic [MW-1:0]        y_mag,
  output logic                 y_detect,
  output logic [15:0]          frame_count
);

  localparam int BW    = $clog2(N);
  localparam int SUM_W = MW + BW;
  localparam int PW    = SUM_W + 32;
  localparam int L     = MAX_BIN - MIN_BIN + 1;

  localparam logic [BW-1:0] MIN_B  = BW'(MIN_BIN);
  localparam logic [BW-1:0] MAX_B  = BW'(MAX_BIN);
  localparam logic [BW-1:0] LAST_B = BW'(N - 1);

  generate
    if (MIN_BIN > MAX_BIN || MAX_BIN >= N) begin : g_bad_window
      $error("fft_peak_detect: search window must satisfy MIN_BIN <= MAX_BIN < N");
    end
  endgenerate

  peak_state_t   state_q, state_d;
  logic [BW-1:0] bin_q, bin_d;
  logic          x_ready_q, x_ready_d;
  logic          y_valid_q, y_valid_d;
  logic [BW-1:0] y_bin_q, y_bin_d;
  logic [MW-1:0] y_mag_q, y_mag_d;
  logic          y_detect_q, y_detect_d;
  logic [15:0]   frame_count_q, frame_count_d;

  logic             x_hs, in_win, accept;
  logic [MW-1:0]    best_mag;
  logic [BW-1:0]    best_bin;
  logic [SUM_W-1:0] sum;
  logic [PW-1:0]    peak_scaled, sum_scaled;

  assign x_hs   = x_valid && x_ready_q;
  assign in_win = (bin_q >= MIN_B) && (bin_q <= MAX_B);
  assign accept = y_valid_q && y_ready;

  window_max #(
    .MW       (MW),
    .BIN_W    (BW),
    .SUM_W    (SUM_W),
    .INIT_BIN (MIN_BIN)
  ) u_window_max (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .en       (x_hs && in_win),
    .data     (x_data),
    .bin      (bin_q),
    .best_mag (best_mag),
    .best_bin (best_bin),
    .sum      (sum)
  );

  // peak >= K * (sum / L) rearranged to avoid division; widths hold the full products.
  assign peak_scaled = PW'(best_mag) * PW'(L);
  assign sum_scaled  = PW'(sum) * PW'(K);

  always_comb begin
    state_d       = state_q;
    bin_d         = bin_q;
    x_ready_d     = x_ready_q;
    y_valid_d     = y_valid_q;
    y_bin_d       = y_bin_q;
    y_mag_d       = y_mag_q;
    y_detect_d    = y_detect_q;
    frame_count_d = frame_count_q;
    case (state_q)
      ACCUM: begin
        if (x_hs) begin
          if (bin_q == LAST_B) begin
            bin_d     = '0;
            state_d   = CALC;
            x_ready_d = 1'b0;
          end else begin
            bin_d = bin_q + BW'(1);
          end
        end
      end
      CALC: begin
        y_bin_d    = best_bin;
        y_mag_d    = best_mag;
        y_detect_d = (peak_scaled >= sum_scaled) && (best_mag != '0);
        y_valid_d  = 1'b1;
        state_d    = REPORT;
      end
      REPORT: begin
        if (y_ready) begin
          y_valid_d     = 1'b0;
          x_ready_d     = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          state_d       = ACCUM;
        end
      end
      default: begin
        state_d   = ACCUM;
        x_ready_d = 1'b1;
        y_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ACCUM;
      bin_q         <= '0;
      x_ready_q     <= 1'b1;
      y_valid_q     <= 1'b0;
      y_bin_q       <= '0;
      y_mag_q       <= '0;
      y_detect_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bin_q         <= bin_d;
      x_ready_q     <= x_ready_d;
      y_valid_q     <= y_valid_d;
      y_bin_q       <= y_bin_d;
      y_mag_q       <= y_mag_d;
      y_detect_q    <= y_detect_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign x_ready     = x_ready_q;
  assign y_valid     = y_valid_q;
  assign y_bin       = y_bin_q;
  assign y_mag       = y_mag_q;
  assign y_detect    = y_detect_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Frame-level bench for fft_peak_detect: directed spectra plus random frames,
// each result compared against a straightforward window scan of the frame.
module tb_fft_peak_detect;
  import fft_pkg::*;

  localparam int NB   = fft_pkg::N;
  localparam int MWB  = fft_pkg::MAG_W;
  localparam int LO   = fft_pkg::MIN_BIN;
  localparam int HI   = fft_pkg::MAX_BIN;
  localparam int KR   = fft_pkg::K_RATIO;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [MWB-1:0]   x_data = '0;
  logic             x_valid = 1'b0;
  logic             x_ready;
  logic             y_valid;
  logic             y_ready = 1'b0;
  logic [BIN_W-1:0] y_bin;
  logic [MWB-1:0]   y_mag;
  logic             y_detect;
  logic [15:0]      frame_count;

  logic [MWB-1:0] fr [NB];
  int             n_checks = 0;
  int             n_fail   = 0;
  int             exp_fc   = 0;
  logic [MWB-1:0] max_mag;

  fft_peak_detect dut (
    .clk         (clk),
    .reset       (reset),
    .x_data      (x_data),
    .x_valid     (x_valid),
    .x_ready     (x_ready),
    .y_valid     (y_valid),
    .y_ready     (y_ready),
    .y_bin       (y_bin),
    .y_mag       (y_mag),
    .y_detect    (y_detect),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: scan the window, strict-greater argmax, exact sum, ratio test.
  function automatic peak_result_t model();
    peak_result_t      r;
    longint unsigned   s = 0;
    longint unsigned   best = 0;
    int                bb = LO;
    for (int b = LO; b <= HI; b++) begin
      s += longint'(fr[b]);
      if (longint'(fr[b]) > best) begin
        best = longint'(fr[b]);
        bb = b;
      end
    end
    r.bin    = BIN_W'(bb);
    r.mag    = MWB'(best);
    r.detect = (best * longint'(HI - LO + 1) >= s * longint'(KR)) && (best != 0);
    return r;
  endfunction

  task automatic fill(input logic [MWB-1:0] v);
    for (int b = 0; b < NB; b++) fr[b] = v;
  endtask

  task automatic send_bins(input int nb, input int gap_pct);
    bit hs;
    int waited;
    for (int b = 0; b < nb; b++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        x_valid = 1'b0;
        @(posedge clk); #1;
      end
      x_valid = 1'b1;
      x_data  = fr[b];
      waited  = 0;
      do begin
        @(negedge clk);
        hs = x_ready;
        @(posedge clk); #1;
        waited++;
      end while (!hs && waited < 200);
      if (!hs) begin
        check("x_ready_timeout", 64'd0, 64'd1);
        x_valid = 1'b0;
        return;
      end
    end
    x_valid = 1'b0;
  endtask

  // Waits for the frame result, checks it, optionally stalls, then accepts it.
  task automatic get_result(input string name, input bit early, input int delay, input int bp_cycles);
    peak_result_t e;
    int cyc = 0;
    int bad = 0;
    e = model();
    if (early) y_ready = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
    end while (!y_valid && cyc < 20);
    check({name, "_latency"}, 64'(cyc <= 3 && y_valid), 64'd1);
    check({name, "_bin"}, 64'(y_bin), 64'(e.bin));
    check({name, "_mag"}, 64'(y_mag), 64'(e.mag));
    check({name, "_detect"}, 64'(y_detect), 64'(e.detect));
    check({name, "_xready_low"}, 64'(x_ready), 64'd0);
    check({name, "_fc_before"}, 64'(frame_count), 64'(exp_fc[15:0]));
    if (!early) begin
      if (bp_cycles > 0) begin
        x_valid = 1'b1;
        x_data  = MWB'($urandom);
      end
      for (int i = 0; i < bp_cycles + delay; i++) begin
        @(negedge clk);
        if (x_ready !== 1'b0 || y_valid !== 1'b1 || y_bin !== e.bin ||
            y_mag !== e.mag || y_detect !== e.detect)
          bad++;
      end
      if (bp_cycles > 0) check({name, "_stall_stable"}, 64'(bad), 64'd0);
      x_valid = 1'b0;
      @(posedge clk); #1;
      y_ready = 1'b1;
    end
    @(posedge clk); #1;
    y_ready = 1'b0;
    exp_fc++;
    @(negedge clk);
    check({name, "_valid_drop"}, 64'(y_valid), 64'd0);
    check({name, "_fc_after"}, 64'(frame_count), 64'(exp_fc[15:0]));
    check({name, "_bin_hold"}, 64'(y_bin), 64'(e.bin));
    check({name, "_xready_back"}, 64'(x_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    max_mag = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_y_valid", 64'(y_valid), 64'd0);
    check("rst_x_ready", 64'(x_ready), 64'd1);
    check("rst_y_bin", 64'(y_bin), 64'd0);
    check("rst_y_mag", 64'(y_mag), 64'd0);
    check("rst_fc", 64'(frame_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    fill(MWB'(10)); fr[50] = MWB'(1000);
    send_bins(NB, 0);
    get_result("tone", 1'b0, 2, 0);

    fill(MWB'(100));
    send_bins(NB, 20);
    get_result("flat", 1'b1, 0, 0);

    fill(MWB'(10)); fr[2] = MWB'(5000); fr[300] = MWB'(6000); fr[120] = MWB'(20);
    send_bins(NB, 0);
    get_result("outwin", 1'b0, 0, 0);

    fill(MWB'(3)); fr[33] = MWB'(900);
    send_bins(NB, 0);
    get_result("bp", 1'b0, 0, 50);
    fill(MWB'(5)); fr[77] = MWB'(4000);
    send_bins(NB, 0);
    get_result("tone77", 1'b0, 0, 0);

    fill('0);
    for (int b = LO; b <= HI; b++) fr[b] = max_mag;
    send_bins(NB, 0);
    get_result("maxval", 1'b0, 1, 0);

    fill('0);
    send_bins(NB, 0);
    get_result("zero", 1'b1, 0, 0);

    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < NB; b++) fr[b] = MWB'({$urandom, $urandom}) >> $urandom_range(32, 0);
      if (f[0]) fr[$urandom_range(HI, LO)] = max_mag >> 1;
      if (f == 4) fr[HI] = max_mag;
      send_bins(NB, 15);
      get_result($sformatf("rnd%0d", f), f[1], $urandom_range(4), 0);
    end

    fill(MWB'(7)); fr[150] = MWB'(99999);
    send_bins(500, 0);
    #2 reset = 1'b0;
    @(negedge clk);
    check("midrst_fc", 64'(frame_count), 64'd0);
    check("midrst_mag", 64'(y_mag), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_fc = 0;
    @(posedge clk); #1;
    fill(MWB'(1)); fr[10] = MWB'(300);
    send_bins(NB, 0);
    get_result("after_rst", 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
